// File: rtl/dot_matrix_scanner.sv
// Row-scan driver for a 16x16 LED dot matrix: BLANK/SHOW per row, frame_done per frame.
// Optional column scrolling is compiled in with `define DOT_SCROLL_EN.
module dot_matrix_scanner #(
  parameter int CLK_DIV       = 4,
  parameter int BLANK_CYCLES  = 1,
  parameter int SCROLL_FRAMES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] col_in,
  output logic [3:0]  row_bin,
  output logic [15:0] row_sel,
  output logic [15:0] col_out,
  output logic        frame_done
);

  localparam int CNT_MAX = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  if (CLK_DIV < 1 || BLANK_CYCLES < 1 || SCROLL_FRAMES < 1) begin : g_param_check
    $error("dot_matrix_scanner: CLK_DIV, BLANK_CYCLES and SCROLL_FRAMES must be >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_SHOW} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_row;
  logic [3:0]       r_row_bin;
  logic [15:0]      r_row_sel;
  logic [15:0]      r_col_out;
  logic             r_frame_done;
  logic [15:0]      w_show_col;
  logic             w_frame_end;

  assign w_frame_end = enable && (r_state == S_SHOW) && (r_cnt == SHOW_LAST) && (r_row == 4'd15);

  function automatic logic [15:0] rotl16(input logic [15:0] v, input logic [3:0] s);
    logic [31:0] w;
    w = {v, v} << s;
    return w[31:16];
  endfunction

`ifdef DOT_SCROLL_EN
  localparam int FRM_W = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(SCROLL_FRAMES - 1);

  logic [3:0]       r_offset;
  logic [FRM_W-1:0] r_frm;

  // Offset and frame count survive enable drops; only rst clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_offset <= 4'd0;
      r_frm    <= '0;
    end else if (w_frame_end) begin
      if (r_frm == FRM_LAST) begin
        r_frm    <= '0;
        r_offset <= r_offset + 4'd1;
      end else begin
        r_frm <= r_frm + 1'b1;
      end
    end
  end

  assign w_show_col = rotl16(col_in, r_offset);
`else
  assign w_show_col = col_in;
`endif

  // r_col_out doubles as the latched column: loaded on SHOW entry, held through SHOW.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_row        <= 4'd0;
      r_row_bin    <= 4'd0;
      r_row_sel    <= 16'd0;
      r_col_out    <= 16'd0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_state   <= S_BLANK;
          r_cnt     <= '0;
          r_row     <= 4'd0;
          r_row_bin <= 4'd0;
        end
        S_BLANK: begin
          if (r_cnt == BLANK_LAST) begin
            r_state   <= S_SHOW;
            r_cnt     <= '0;
            r_row_sel <= 16'd1 << r_row;
            r_col_out <= w_show_col;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_SHOW: begin
          if (r_cnt == SHOW_LAST) begin
            r_state      <= S_BLANK;
            r_cnt        <= '0;
            r_row        <= r_row + 4'd1;
            r_row_bin    <= r_row + 4'd1;
            r_row_sel    <= 16'd0;
            r_col_out    <= 16'd0;
            r_frame_done <= w_frame_end;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign row_bin    = r_row_bin;
  assign row_sel    = r_row_sel;
  assign col_out    = r_col_out;
  assign frame_done = r_frame_done;

endmodule
